// File: rtl/frac_tcam_pkg.sv
// Shared types and constants for the fractured TCAM front-end.
// A rule is stored per 5-bit slice so the encoder sees only the bits it programs.
package frac_tcam_pkg;

    localparam int KW          = 5;
    localparam int SLICE_DEPTH = 32;
    localparam int GROUP_ROWS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP,
        DONE
    } state_t;

    typedef struct packed {
        logic [KW-1:0] value;
        logic [KW-1:0] mask;
        logic          en;
    } slice_rule_t;

endpackage

// File: rtl/tcam_update_ctrl_slice_rule_encoder.sv
// Builds one slice's 8-bit LUTRAM column: bit r is set when rule r matches
// the 5-bit key k on this slice (mask bits are don't-care).
module slice_rule_encoder
    import frac_tcam_pkg::*;
(
    input  logic [KW-1:0]                 k,
    input  slice_rule_t [GROUP_ROWS-1:0]  rules,
    output logic [GROUP_ROWS-1:0]         column
);

    always_comb begin
        column = '0;
        for (int r = 0; r < GROUP_ROWS; r++) begin
            column[r] = rules[r].en &&
                        (((k ^ rules[r].value) & ~rules[r].mask) == '0);
        end
    end

endmodule

// File: rtl/tcam_update_ctrl.sv
// TCAM front-end: arbitrates searches against rule updates and turns a
// buffered group of 8 ternary rules into the 32-cycle LUTRAM write sweep.
module tcam_update_ctrl
    import frac_tcam_pkg::*;
#(
    parameter  int W  = 20,
    parameter  int D  = 64,
    localparam int N  = W / KW,
    localparam int G  = D / GROUP_ROWS,
    localparam int GW = (G > 1) ? $clog2(G) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      srch_key,
    input  logic              srch_valid,
    output logic              srch_ready,
    output logic              srch_issue,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [GW-1:0]     upd_group,
    input  logic [W-1:0]      upd_value,
    input  logic [W-1:0]      upd_mask,
    input  logic              upd_en,
    output logic              upd_done,
    output logic [W-1:0]      tcam_sk,
    output logic [G-1:0]      tcam_we,
    output logic [8*N-1:0]    tcam_rules
);

    state_t                   state, state_nxt;
    logic [2:0]               beat, beat_nxt;
    logic [4:0]               k, k_nxt;
    logic [GW-1:0]            group, group_nxt;
    logic [W-1:0]             value_q   [GROUP_ROWS];
    logic [W-1:0]             mask_q    [GROUP_ROWS];
    logic [GROUP_ROWS-1:0]    en_q;
    logic [W-1:0]             value_nxt [GROUP_ROWS];
    logic [W-1:0]             mask_nxt  [GROUP_ROWS];
    logic [GROUP_ROWS-1:0]    en_nxt;
    logic [G-1:0]             we_nxt;
    logic [8*N-1:0]           col_nxt;
    logic                     pend_valid;
    logic [W-1:0]             pend_key;
    logic                     upd_fire;
    logic                     srch_fire;

    assign upd_fire  = upd_valid && upd_ready;
    assign srch_fire = srch_valid && srch_ready;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        k_nxt     = k;
        group_nxt = group;
        case (state)
            IDLE: begin
                if (upd_fire) begin
                    group_nxt = upd_group;
                    beat_nxt  = beat + 3'd1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (upd_fire) begin
                    beat_nxt = beat + 3'd1;
                    if (beat == 3'd7) begin
                        k_nxt     = 5'd0;
                        state_nxt = SWEEP;
                    end
                end
            end
            SWEEP: begin
                k_nxt = k + 5'd1;
                if (k == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The encoder sees the rule set including the beat being accepted, so the
    // k=0 write data is ready on the same edge that takes beat 7.
    always_comb begin
        value_nxt = value_q;
        mask_nxt  = mask_q;
        en_nxt    = en_q;
        if (upd_fire) begin
            value_nxt[beat] = upd_value;
            mask_nxt[beat]  = upd_mask;
            en_nxt[beat]    = upd_en;
        end
    end

    always_comb begin
        we_nxt = '0;
        for (int g = 0; g < G; g++) begin
            if (int'(group_nxt) == g) begin
                we_nxt[g] = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < N; s++) begin : g_slice
        slice_rule_t [GROUP_ROWS-1:0] slice_rules;
        for (genvar r = 0; r < GROUP_ROWS; r++) begin : g_row
            assign slice_rules[r] = {value_nxt[r][KW*s +: KW],
                                     mask_nxt[r][KW*s +: KW],
                                     en_nxt[r]};
        end
        slice_rule_encoder u_enc (
            .k      (k_nxt),
            .rules  (slice_rules),
            .column (col_nxt[8*s +: 8])
        );
    end

    // A search accepted alongside beat 7 cannot use tcam_sk during the sweep,
    // so it is parked and issued in the DONE cycle ahead of any later search.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= 3'd0;
            k          <= 5'd0;
            group      <= '0;
            en_q       <= '0;
            pend_valid <= 1'b0;
            pend_key   <= '0;
            srch_ready <= 1'b1;
            upd_ready  <= 1'b1;
            srch_issue <= 1'b0;
            upd_done   <= 1'b0;
            tcam_we    <= '0;
            tcam_sk    <= '0;
            tcam_rules <= '0;
            for (int r = 0; r < GROUP_ROWS; r++) begin
                value_q[r] <= '0;
                mask_q[r]  <= '0;
            end
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            k          <= k_nxt;
            group      <= group_nxt;
            value_q    <= value_nxt;
            mask_q     <= mask_nxt;
            en_q       <= en_nxt;
            srch_ready <= (state_nxt != SWEEP);
            upd_ready  <= (state_nxt == IDLE) || (state_nxt == LOAD);
            upd_done   <= (state_nxt == DONE);
            srch_issue <= 1'b0;
            tcam_we    <= '0;
            if (state_nxt == SWEEP) begin
                tcam_we    <= we_nxt;
                tcam_sk    <= {N{k_nxt}};
                tcam_rules <= col_nxt;
                if (srch_fire) begin
                    pend_valid <= 1'b1;
                    pend_key   <= srch_key;
                end
            end else if (pend_valid) begin
                tcam_sk    <= pend_key;
                srch_issue <= 1'b1;
                pend_valid <= 1'b0;
            end else if (srch_fire) begin
                tcam_sk    <= srch_key;
                srch_issue <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// Scoreboard bench for tcam_update_ctrl: a rule-level reference model queues
// expected search issues, sweep writes and done pulses; a monitor checks them.
module tb_tcam_update_ctrl;
    import frac_tcam_pkg::*;

    localparam int W  = 20;
    localparam int D  = 64;
    localparam int N  = W / KW;
    localparam int G  = D / GROUP_ROWS;
    localparam int GW = $clog2(G);

    logic              clk;
    logic              reset;
    logic [W-1:0]      srch_key;
    logic              srch_valid;
    logic              srch_ready;
    logic              srch_issue;
    logic              upd_valid;
    logic              upd_ready;
    logic [GW-1:0]     upd_group;
    logic [W-1:0]      upd_value;
    logic [W-1:0]      upd_mask;
    logic              upd_en;
    logic              upd_done;
    logic [W-1:0]      tcam_sk;
    logic [G-1:0]      tcam_we;
    logic [8*N-1:0]    tcam_rules;

    tcam_update_ctrl #(.W(W), .D(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .srch_key   (srch_key),
        .srch_valid (srch_valid),
        .srch_ready (srch_ready),
        .srch_issue (srch_issue),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_group  (upd_group),
        .upd_value  (upd_value),
        .upd_mask   (upd_mask),
        .upd_en     (upd_en),
        .upd_done   (upd_done),
        .tcam_sk    (tcam_sk),
        .tcam_we    (tcam_we),
        .tcam_rules (tcam_rules)
    );

    typedef struct {
        logic [GW-1:0] group;
        logic [W-1:0]  value;
        logic [W-1:0]  mask;
        logic          en;
    } beat_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] key;
    } srch_exp_t;

    typedef struct {
        int             cyc;
        logic [G-1:0]   we;
        logic [W-1:0]   sk;
        logic [8*N-1:0] rules;
    } wr_exp_t;

    beat_t     beat_q [$];
    srch_exp_t srch_q [$];
    wr_exp_t   wr_q   [$];
    int        done_q [$];

    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   b7_cyc     = -1000;
    int   m_beats    = 0;
    bit   check_en   = 0;
    logic exp_srch_rdy = 1'b1;
    logic exp_upd_rdy  = 1'b1;
    logic [GW-1:0] m_grp;
    logic [W-1:0]  m_val [GROUP_ROWS];
    logic [W-1:0]  m_msk [GROUP_ROWS];
    logic          m_en  [GROUP_ROWS];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Row r matches key k on a slice when every unmasked bit agrees.
    function automatic logic [8*N-1:0] model_column(input int k);
        logic [8*N-1:0] col;
        bit             hit;
        col = '0;
        for (int s = 0; s < N; s++) begin
            for (int r = 0; r < GROUP_ROWS; r++) begin
                hit = m_en[r];
                for (int b = 0; b < KW; b++) begin
                    if (!m_msk[r][KW*s + b] && (((k >> b) & 1) != int'(m_val[r][KW*s + b])))
                        hit = 0;
                end
                col[8*s + r] = hit;
            end
        end
        return col;
    endfunction

    task automatic push_rule(input int group, input logic [W-1:0] value,
                             input logic [W-1:0] mask, input bit en);
        beat_t b;
        b.group = GW'(group);
        b.value = value;
        b.mask  = mask;
        b.en    = en;
        beat_q.push_back(b);
    endtask

    // One clock of stimulus; the model decides acceptance from its own
    // notion of when the sweep occupies the array.
    task automatic apply_stimulus(input bit s_valid, input logic [W-1:0] s_key, input bit u_try);
        int        c;
        beat_t     b;
        wr_exp_t   w;
        srch_exp_t se;
        logic [4:0] k5;
        @(posedge clk);
        #1;
        c            = cyc;
        reset        = 1'b0;
        exp_srch_rdy = !(c >= b7_cyc + 1 && c <= b7_cyc + 32);
        exp_upd_rdy  = !(c >= b7_cyc + 1 && c <= b7_cyc + 33);
        srch_valid   = s_valid;
        srch_key     = s_key;
        upd_valid    = u_try && (beat_q.size() > 0);
        if (upd_valid) begin
            upd_group = beat_q[0].group;
            upd_value = beat_q[0].value;
            upd_mask  = beat_q[0].mask;
            upd_en    = beat_q[0].en;
        end else begin
            upd_group = GW'($urandom);
            upd_value = W'($urandom);
            upd_mask  = W'($urandom);
            upd_en    = 1'($urandom);
        end
        if (upd_valid && exp_upd_rdy) begin
            b = beat_q.pop_front();
            if (m_beats == 0) m_grp = b.group;
            m_val[m_beats] = b.value;
            m_msk[m_beats] = b.mask;
            m_en[m_beats]  = b.en;
            m_beats++;
            if (m_beats == GROUP_ROWS) begin
                m_beats = 0;
                b7_cyc  = c;
                for (int k = 0; k < SLICE_DEPTH; k++) begin
                    k5      = 5'(k);
                    w.cyc   = c + 1 + k;
                    w.we    = '0;
                    if (int'(m_grp) < G) w.we[m_grp] = 1'b1;
                    w.sk    = {N{k5}};
                    w.rules = model_column(k);
                    wr_q.push_back(w);
                end
                done_q.push_back(c + 33);
            end
        end
        if (s_valid && exp_srch_rdy) begin
            se.cyc = (b7_cyc == c) ? c + 33 : c + 1;
            se.key = s_key;
            srch_q.push_back(se);
        end
    endtask

    task automatic do_reset();
        int c;
        @(posedge clk);
        #1;
        c            = cyc;
        exp_srch_rdy = !(c >= b7_cyc + 1 && c <= b7_cyc + 32);
        exp_upd_rdy  = !(c >= b7_cyc + 1 && c <= b7_cyc + 33);
        reset        = 1'b1;
        srch_valid   = 1'b0;
        upd_valid    = 1'b0;
        while (srch_q.size() > 0 && srch_q[$].cyc > c) void'(srch_q.pop_back());
        while (wr_q.size() > 0 && wr_q[$].cyc > c) void'(wr_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
        beat_q.delete();
        m_beats = 0;
        b7_cyc  = -1000;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        exp_srch_rdy = 1'b1;
        exp_upd_rdy  = 1'b1;
    endtask

    // Monitor: consumes expectations whenever the DUT presents an event and
    // flags any expected event whose cycle passes without it.
    always @(negedge clk) begin
        srch_exp_t se;
        wr_exp_t   we;
        int        dc;
        if (check_en) begin
            compare("srch_ready", 64'(srch_ready), 64'(exp_srch_rdy));
            compare("upd_ready", 64'(upd_ready), 64'(exp_upd_rdy));
            if (srch_issue) begin
                if (srch_q.size() == 0) begin
                    compare("srch_issue_unexpected", 64'(srch_issue), 64'd0);
                end else begin
                    se = srch_q.pop_front();
                    compare("srch_issue_cycle", 64'(cyc), 64'(se.cyc));
                    compare("srch_issue_key", 64'(tcam_sk), 64'(se.key));
                end
            end else if (srch_q.size() > 0 && srch_q[0].cyc <= cyc) begin
                se = srch_q.pop_front();
                compare("srch_issue_missing", 64'(srch_issue), 64'd1);
            end
            if (tcam_we != '0) begin
                if (wr_q.size() == 0) begin
                    compare("write_unexpected", 64'(tcam_we), 64'd0);
                end else begin
                    we = wr_q.pop_front();
                    compare("write_cycle", 64'(cyc), 64'(we.cyc));
                    compare("write_we", 64'(tcam_we), 64'(we.we));
                    compare("write_sk", 64'(tcam_sk), 64'(we.sk));
                    compare("write_rules", 64'(tcam_rules), 64'(we.rules));
                end
            end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
                we = wr_q.pop_front();
                compare("write_missing", 64'(tcam_we), 64'(we.we));
            end
            if (upd_done) begin
                if (done_q.size() == 0) begin
                    compare("upd_done_unexpected", 64'(upd_done), 64'd0);
                end else begin
                    dc = done_q.pop_front();
                    compare("upd_done_cycle", 64'(cyc), 64'(dc));
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                dc = done_q.pop_front();
                compare("upd_done_missing", 64'(upd_done), 64'd1);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        srch_valid = 1'b0;
        srch_key   = '0;
        upd_valid  = 1'b0;
        upd_group  = '0;
        upd_value  = '0;
        upd_mask   = '0;
        upd_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1;
        @(negedge clk);
        compare("rst_tcam_sk", 64'(tcam_sk), 64'd0);
        compare("rst_tcam_rules", 64'(tcam_rules), 64'd0);
        compare("rst_tcam_we", 64'(tcam_we), 64'd0);
        compare("rst_srch_issue", 64'(srch_issue), 64'd0);
        compare("rst_upd_done", 64'(upd_done), 64'd0);
        compare("rst_srch_ready", 64'(srch_ready), 64'd1);
        compare("rst_upd_ready", 64'(upd_ready), 64'd1);

        // Back-to-back searches.
        apply_stimulus(1'b1, 20'h12345, 1'b0);
        apply_stimulus(1'b1, 20'hABCDE, 1'b0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b0);

        // Group 2: exact-match rule 0, all-don't-care rule 3, searches held valid.
        push_rule(2, 20'h0001F, 20'h00000, 1'b1);
        for (int r = 1; r < GROUP_ROWS; r++) begin
            if (r == 3) push_rule(2, W'($urandom), 20'hFFFFF, 1'b1);
            else        push_rule(2, W'($urandom), W'($urandom), 1'b0);
        end
        for (int i = 0; i < 45; i++) apply_stimulus(1'b1, W'($urandom), 1'b1);
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);

        // Beats with 3-cycle gaps and a search accepted in LOAD.
        for (int r = 0; r < GROUP_ROWS; r++)
            push_rule($urandom_range(0, G - 1), W'($urandom), W'($urandom & $urandom), 1'b1);
        for (int i = 0; i < 100 && beat_q.size() > 0; i++)
            apply_stimulus(i == 5, W'($urandom), (i % 4) == 3);
        repeat (40) apply_stimulus(1'b0, '0, 1'b0);

        // Reset while the sweep shows k=10.
        for (int r = 0; r < GROUP_ROWS; r++)
            push_rule(5, W'($urandom), W'($urandom & $urandom), 1'b1);
        for (int i = 0; i < 20 && beat_q.size() > 0; i++) apply_stimulus(1'b0, '0, 1'b1);
        repeat (10) apply_stimulus(1'b0, '0, 1'b0);
        do_reset();
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);

        // Randomized traffic.
        repeat (6) begin
            for (int r = 0; r < GROUP_ROWS; r++)
                push_rule($urandom_range(0, G - 1), W'($urandom),
                          W'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
            for (int i = 0; i < 300 && beat_q.size() > 0; i++)
                apply_stimulus(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 2) != 0);
            for (int i = 0; i < 10; i++)
                apply_stimulus(1'($urandom_range(0, 1)), W'($urandom), 1'b0);
        end
        repeat (40) apply_stimulus(1'b0, '0, 1'b0);

        compare("srch_q_drained", 64'(srch_q.size()), 64'd0);
        compare("wr_q_drained", 64'(wr_q.size()), 64'd0);
        compare("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tcam_update_ctrl.md
Name: tcam_update_ctrl

Overview:
- Upstream front-end for the fractured TCAM array: owns the array's sk / we / rules inputs.
- Arbitrates between search keys and rule updates.
- Converts a group of 8 ternary rules (value + mask) into the 32-cycle LUTRAM sweep that programs one 8-row group across all 5-bit slices.
- Searches stall only while a sweep is in progress.

Parameters:
- W, 20, key width in bits; multiple of 5.
- D, 64, TCAM depth in rules; multiple of 8.
- n, W/5, number of 5-bit slices (derived).
- G, D/8, number of 8-row write groups (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- srch_key  in  W  search key.
- srch_valid  in  1  search request.
- srch_ready  out  1  search accepted when srch_valid && srch_ready.
- srch_issue  out  1  pulses in the cycle tcam_sk carries an accepted search key.
- upd_valid  in  1  rule beat valid.
- upd_ready  out  1  rule beat accepted when upd_valid && upd_ready.
- upd_group  in  clog2(G)  target group; sampled on first beat only.
- upd_value  in  W  rule value.
- upd_mask  in  W  rule mask; 1 = don't care.
- upd_en  in  1  rule enabled; a disabled rule never matches.
- upd_done  out  1  one-cycle pulse when the group has been written.
- tcam_sk  out  W  TCAM key / LUTRAM address.
- tcam_we  out  G  one-hot group write enable.
- tcam_rules  out  8n  write data; byte s feeds slice s.

Behaviour:
- All outputs are registered.
- Reset values: srch_ready=1, upd_ready=1, srch_issue=0, upd_done=0, tcam_we=0, tcam_sk=0, tcam_rules=0, state=IDLE, beat and sweep counters 0.
- States:
  - IDLE: upd_ready=1. An accepted beat stores rule 0, latches upd_group, sets beat=1, moves to LOAD.
  - LOAD: upd_ready=1. Each accepted beat stores rule[beat] and increments beat. Accepting rule 7 moves to SWEEP and clears the sweep counter k.
  - SWEEP: 32 cycles, k=0..31. Per cycle:
    - tcam_we = one-hot(group).
    - tcam_sk = k replicated in every 5-bit slice.
    - tcam_rules[8s+r] = en_r && (((k ^ value_r[5s+4:5s]) & ~mask_r[5s+4:5s]) == 0).
    - Bit r of every slice byte programs TCAM row 8*group + r.
    - upd_ready=0, srch_ready=0.
    - After k=31, moves to DONE.
  - DONE: one cycle. tcam_we=0, upd_done=1, srch_ready=1. Returns to IDLE.
- Timing: the first SWEEP write cycle follows the edge that accepts beat 7. upd_done is high exactly 33 cycles after that acceptance.
- Search path:
  - Accepted in IDLE, LOAD and DONE.
  - Accepted key appears on tcam_sk the next cycle with srch_issue=1.
  - Otherwise tcam_sk holds its value, except during SWEEP.
  - srch_ready deasserts in the same registered update that enters SWEEP, so no search is accepted in the cycle a sweep begins.
- Simultaneous events:
  - A search and an update beat in the same cycle in IDLE or LOAD are both accepted.
  - Beats may be non-contiguous; LOAD waits indefinitely for them.
- Reset mid-operation: returns to IDLE within one cycle. Buffered rules are discarded and tcam_we drops. A partially swept group is undefined and must be rewritten by software.
- upd_group values >= G: tcam_we stays 0 for the whole sweep, i.e. no write. upd_done still pulses.

Decomposition:
- Shared package frac_tcam_pkg holds:
  - KW=5, SLICE_DEPTH=32, GROUP_ROWS=8.
  - State enum IDLE/LOAD/SWEEP/DONE.
  - Rule struct {value, mask, en}.
- One natural sub-module: slice_rule_encoder. It is combinational, instanced n times. Inputs: k[4:0] and 8 rule slices (5-bit value + 5-bit mask + en). Output: the 8-bit column.

Test Plan:
- Reset, then searches 0x12345, 0xABCDE back-to-back -> srch_ready=1 throughout; tcam_sk shows each key one cycle after acceptance with srch_issue=1.
- Group 2, rule 0 = value 0x0001F mask 0 en=1, rules 1-7 en=0 -> 32 write cycles, tcam_we=8'b00000100:
  - slice 0 byte = 0x01 only at k=31; 0x00 at all other k.
  - slices 1-3 bytes = 0x01 only at k=0.
  - upd_done asserts 33 cycles after beat 7.
- Rule 3 mask = 0xFFFFF, en=1 -> bit 3 of every slice byte = 1 for all 32 k.
- Search held valid during a sweep -> srch_ready=0 for 32 cycles, no srch_issue; key issued the cycle after DONE.
- Reset asserted at sweep k=10 -> next cycle tcam_we=0, state IDLE, upd_ready=1, no upd_done.
- Beats with 3-cycle gaps, plus a search accepted in LOAD -> search issued normally; sweep starts only after beat 7.
